// File: rtl/rom_loader_pkg.sv
// Shared FSM encoding and constants for the ROM download loader.
package rom_loader_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_WRITE, ST_FLUSH} state_e;
   localparam int         MAX_REGIONS  = 8;
   localparam int         REGION_IDX_W = $clog2(MAX_REGIONS);
   localparam logic [7:0] LANE_FILL    = 8'hFF;
endpackage

// File: rtl/rom_region_decode.sv
// Maps a download byte address to a one-hot region and an offset from its base.
// Latency: combinational.
// Backpressure: none; pure decode.
module rom_region_decode import rom_loader_pkg::*; #(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_W      = 17
) (
   input  logic [ADDR_W-1:0]             addr_i,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_base_i,
   output logic [NUM_REGIONS-1:0]        sel_o,
   output logic [ADDR_W-1:0]             offset_o
);
   logic [REGION_IDX_W-1:0] idx;
   logic [ADDR_W-1:0]       base_sel;

   // Bases ascend, so the last match is the highest base not above the address.
   always_comb begin
      idx      = '0;
      base_sel = '0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
         if (region_base_i[r*ADDR_W +: ADDR_W] <= addr_i) begin
            idx      = REGION_IDX_W'(r);
            base_sel = region_base_i[r*ADDR_W +: ADDR_W];
         end
      end
      sel_o = '0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
         sel_o[r] = (idx == REGION_IDX_W'(r));
      end
      offset_o = addr_i - base_sel;
   end
endmodule

// File: rtl/rom_loader.sv
// Packs ioctl download bytes into ROM words and writes them to the selected region.
// Latency: one cycle from the word-completing ioctl_wr to rom_we.
// Backpressure: ioctl_wait holds the host off while a word waits for rom_ready.
module rom_loader import rom_loader_pkg::*; #(
   parameter int         NUM_REGIONS = 4,
   parameter int         DATA_W      = 8,
   parameter int         ADDR_W      = 17,
   parameter logic [7:0] ROM_INDEX   = 8'd0
) (
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic                          ioctl_download,
   input  logic [7:0]                    ioctl_index,
   input  logic                          ioctl_wr,
   input  logic [ADDR_W-1:0]             ioctl_addr,
   input  logic [7:0]                    ioctl_dout,
   output logic                          ioctl_wait,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
   output logic [NUM_REGIONS-1:0]        rom_we,
   output logic [ADDR_W-1:0]             rom_addr,
   output logic [DATA_W-1:0]             rom_data,
   input  logic                          rom_ready,
   output logic                          load_done,
   output logic                          load_err
);
   localparam int SHIFT = (DATA_W == 16) ? 1 : 0;

   function automatic logic [DATA_W-1:0] pack(input logic [7:0] hi, input logic [7:0] lo);
      return DATA_W'({hi, lo});
   endfunction

   state_e                  state_q, state_d;
   logic                    sess, sess_q, capture, busy;
   logic [7:0]              lo_q, lo_d;
   logic                    half_q, half_d, have_exp_q, have_exp_d, nvld_q, nvld_d;
   logic                    done_q, done_d, err_q, err_d;
   logic [NUM_REGIONS-1:0]  wsel_q, wsel_d, osel_q, osel_d, nsel_q, nsel_d, dec_sel;
   logic [ADDR_W-1:0]       waddr_q, waddr_d, oaddr_q, oaddr_d, naddr_q, naddr_d;
   logic [ADDR_W-1:0]       exp_q, exp_d, dec_off, word_off;
   logic [DATA_W-1:0]       odata_q, odata_d, ndata_q, ndata_d;

   rom_region_decode #(.NUM_REGIONS(NUM_REGIONS), .ADDR_W(ADDR_W)) u_decode (
      .addr_i        (ioctl_addr),
      .region_base_i (region_base),
      .sel_o         (dec_sel),
      .offset_o      (dec_off)
   );

   assign sess       = ioctl_download && (ioctl_index == ROM_INDEX);
   assign busy       = (state_q == ST_WRITE) || (state_q == ST_FLUSH);
   assign capture    = (state_q == ST_COLLECT) && sess && ioctl_wr;
   assign word_off   = dec_off >> SHIFT;
   assign ioctl_wait = busy || capture;
   assign rom_we     = busy ? osel_q : '0;
   assign rom_addr   = oaddr_q;
   assign rom_data   = odata_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      half_d     = half_q;
      have_exp_d = have_exp_q;
      exp_d      = exp_q;
      wsel_d     = wsel_q;
      waddr_d    = waddr_q;
      osel_d     = osel_q;
      oaddr_d    = oaddr_q;
      odata_d    = odata_q;
      nsel_d     = nsel_q;
      naddr_d    = naddr_q;
      ndata_d    = ndata_q;
      nvld_d     = nvld_q;
      done_d     = 1'b0;
      err_d      = err_q;
      if (busy && sess && ioctl_wr) err_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (sess && !sess_q) begin
               state_d    = ST_COLLECT;
               err_d      = 1'b0;
               half_d     = 1'b0;
               have_exp_d = 1'b0;
               nvld_d     = 1'b0;
            end
         end
         ST_COLLECT: begin
            if (!sess) begin
               if (half_q) begin
                  state_d = ST_FLUSH;
                  osel_d  = wsel_q;
                  oaddr_d = waddr_q;
                  odata_d = pack(LANE_FILL, lo_q);
                  half_d  = 1'b0;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (ioctl_wr) begin
               exp_d      = ioctl_addr + ADDR_W'(1);
               have_exp_d = 1'b1;
               if (have_exp_q && (ioctl_addr != exp_q)) err_d = 1'b1;
               if (DATA_W != 16) begin
                  osel_d  = dec_sel;
                  oaddr_d = word_off;
                  odata_d = pack(LANE_FILL, ioctl_dout);
                  state_d = ST_WRITE;
               end else if (!ioctl_addr[0]) begin
                  // A new even byte while one is pending flushes the orphan first.
                  lo_d    = ioctl_dout;
                  half_d  = 1'b1;
                  wsel_d  = dec_sel;
                  waddr_d = word_off;
                  if (half_q) begin
                     osel_d  = wsel_q;
                     oaddr_d = waddr_q;
                     odata_d = pack(LANE_FILL, lo_q);
                     state_d = ST_WRITE;
                  end
               end else if (half_q && (ioctl_addr == exp_q)) begin
                  osel_d  = wsel_q;
                  oaddr_d = waddr_q;
                  odata_d = pack(ioctl_dout, lo_q);
                  half_d  = 1'b0;
                  state_d = ST_WRITE;
               end else begin
                  err_d   = 1'b1;
                  half_d  = 1'b0;
                  state_d = ST_WRITE;
                  if (half_q) begin
                     osel_d  = wsel_q;
                     oaddr_d = waddr_q;
                     odata_d = pack(LANE_FILL, lo_q);
                     nsel_d  = dec_sel;
                     naddr_d = word_off;
                     ndata_d = pack(ioctl_dout, LANE_FILL);
                     nvld_d  = 1'b1;
                  end else begin
                     osel_d  = dec_sel;
                     oaddr_d = word_off;
                     odata_d = pack(ioctl_dout, LANE_FILL);
                  end
               end
            end
         end
         ST_WRITE: begin
            if (rom_ready) begin
               if (nvld_q) begin
                  osel_d  = nsel_q;
                  oaddr_d = naddr_q;
                  odata_d = ndata_q;
                  nvld_d  = 1'b0;
               end else if (!sess) begin
                  if (half_q) begin
                     state_d = ST_FLUSH;
                     osel_d  = wsel_q;
                     oaddr_d = waddr_q;
                     odata_d = pack(LANE_FILL, lo_q);
                     half_d  = 1'b0;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_FLUSH: begin
            if (rom_ready) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // sess_q resets high so a session already open at reset release is not seen as a rise.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         sess_q     <= 1'b1;
         lo_q       <= '0;
         half_q     <= 1'b0;
         have_exp_q <= 1'b0;
         exp_q      <= '0;
         wsel_q     <= '0;
         waddr_q    <= '0;
         osel_q     <= '0;
         oaddr_q    <= '0;
         odata_q    <= '0;
         nsel_q     <= '0;
         naddr_q    <= '0;
         ndata_q    <= '0;
         nvld_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sess_q     <= sess;
         lo_q       <= lo_d;
         half_q     <= half_d;
         have_exp_q <= have_exp_d;
         exp_q      <= exp_d;
         wsel_q     <= wsel_d;
         waddr_q    <= waddr_d;
         osel_q     <= osel_d;
         oaddr_q    <= oaddr_d;
         odata_q    <= odata_d;
         nsel_q     <= nsel_d;
         naddr_q    <= naddr_d;
         ndata_q    <= ndata_d;
         nvld_q     <= nvld_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench: one 8-bit and one 16-bit loader driven side by side.
module tb_rom_loader;
   localparam int NR = 4;
   localparam int AW = 17;

   logic clk_sys = 1'b0;
   logic reset_n;
   logic [NR*AW-1:0] region_base;

   logic          a_dl, a_wr, a_ready, a_wait, a_done, a_err;
   logic [7:0]    a_idx, a_dout;
   logic [AW-1:0] a_addr, a_raddr;
   logic [NR-1:0] a_we;
   logic [7:0]    a_rdata;

   logic          b_dl, b_wr, b_ready, b_wait, b_done, b_err;
   logic [7:0]    b_idx, b_dout;
   logic [AW-1:0] b_addr, b_raddr;
   logic [NR-1:0] b_we;
   logic [15:0]   b_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk_sys = ~clk_sys;

   rom_loader #(.NUM_REGIONS(NR), .DATA_W(8), .ADDR_W(AW), .ROM_INDEX(8'd0)) u8 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(a_dl), .ioctl_index(a_idx),
      .ioctl_wr(a_wr), .ioctl_addr(a_addr), .ioctl_dout(a_dout), .ioctl_wait(a_wait),
      .region_base(region_base), .rom_we(a_we), .rom_addr(a_raddr), .rom_data(a_rdata),
      .rom_ready(a_ready), .load_done(a_done), .load_err(a_err));

   rom_loader #(.NUM_REGIONS(NR), .DATA_W(16), .ADDR_W(AW), .ROM_INDEX(8'd0)) u16 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(b_dl), .ioctl_index(b_idx),
      .ioctl_wr(b_wr), .ioctl_addr(b_addr), .ioctl_dout(b_dout), .ioctl_wait(b_wait),
      .region_base(region_base), .rom_we(b_we), .rom_addr(b_raddr), .rom_data(b_rdata),
      .rom_ready(b_ready), .load_done(b_done), .load_err(b_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      region_base = {17'h0C000, 17'h08000, 17'h04000, 17'h00000};
      a_dl = 0; a_idx = 0; a_wr = 0; a_addr = 0; a_dout = 0; a_ready = 1;
      b_dl = 0; b_idx = 0; b_wr = 0; b_addr = 0; b_dout = 0; b_ready = 1;
      #3;
      chk("rst_we8",   32'(a_we), 0);
      chk("rst_addr8", 32'(a_raddr), 0);
      chk("rst_data8", 32'(a_rdata), 0);
      chk("rst_wait8", 32'(a_wait), 0);
      chk("rst_done8", 32'(a_done), 0);
      chk("rst_err8",  32'(a_err), 0);
      chk("rst_we16",  32'(b_we), 0);
      cyc(); cyc();
      reset_n = 1'b1;
      cyc(); cyc();

      // 8-bit: word crossing from region 0 into region 1
      a_dl = 1; cyc();
      a_wr = 1; a_addr = 17'h03FFF; a_dout = 8'hAA; #1;
      chk("cap_wait8", 32'(a_wait), 1);
      cyc(); a_wr = 0;
      chk("w0_we",   32'(a_we), 32'h1);
      chk("w0_addr", 32'(a_raddr), 32'h3FFF);
      chk("w0_data", 32'(a_rdata), 32'hAA);
      chk("w0_wait", 32'(a_wait), 1);
      cyc();
      chk("w0_done_we",   32'(a_we), 0);
      chk("w0_done_wait", 32'(a_wait), 0);
      a_wr = 1; a_addr = 17'h04000; a_dout = 8'h55;
      cyc(); a_wr = 0;
      chk("w1_we",   32'(a_we), 32'h2);
      chk("w1_addr", 32'(a_raddr), 0);
      chk("w1_data", 32'(a_rdata), 32'h55);
      cyc();

      // 8-bit: rom_ready held low for five cycles
      a_ready = 0; a_wr = 1; a_addr = 17'h04001; a_dout = 8'h66;
      cyc(); a_wr = 0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_we",   32'(a_we), 32'h2);
         chk("stall_addr", 32'(a_raddr), 32'h1);
         chk("stall_data", 32'(a_rdata), 32'h66);
         chk("stall_wait", 32'(a_wait), 1);
         cyc();
      end
      a_ready = 1; #1;
      chk("stall_last_we", 32'(a_we), 32'h2);
      cyc();
      chk("stall_rel_we", 32'(a_we), 0);
      chk("seq_err8",     32'(a_err), 0);
      a_dl = 0; cyc();
      chk("end_done8", 32'(a_done), 1);
      cyc();
      chk("end_done8_pulse", 32'(a_done), 0);

      // 8-bit: foreign index is ignored
      a_dl = 1; a_idx = 8'd1; cyc(); cyc();
      a_wr = 1; a_addr = 17'h5; a_dout = 8'h11; cyc(); a_wr = 0;
      chk("idx1_we",   32'(a_we), 0);
      chk("idx1_wait", 32'(a_wait), 0);
      a_dl = 0; cyc(); cyc();
      chk("idx1_done", 32'(a_done), 0);
      a_idx = 8'd0;

      // 8-bit: strobe while ioctl_wait is high
      a_dl = 1; cyc();
      a_ready = 0; a_wr = 1; a_addr = 17'h0; a_dout = 8'h21; cyc();
      a_addr = 17'h1; a_dout = 8'h22; cyc(); a_wr = 0;
      chk("viol_err",  32'(a_err), 1);
      chk("viol_we",   32'(a_we), 32'h1);
      chk("viol_data", 32'(a_rdata), 32'h21);
      a_ready = 1; cyc();
      chk("viol_rel_we", 32'(a_we), 0);
      a_dl = 0; cyc();
      chk("viol_done",  32'(a_done), 1);
      chk("viol_err_sticky", 32'(a_err), 1);
      cyc();
      a_dl = 1; cyc();
      chk("viol_err_clr", 32'(a_err), 0);
      a_dl = 0; cyc(); cyc();

      // 16-bit: even/odd pair forms one word
      b_dl = 1; cyc();
      b_wr = 1; b_addr = 17'h10; b_dout = 8'h34; #1;
      chk("lo_wait16", 32'(b_wait), 1);
      cyc(); b_wr = 0; #1;
      chk("lo_we16",   32'(b_we), 0);
      chk("lo_idle_wait16", 32'(b_wait), 0);
      b_ready = 0; b_wr = 1; b_addr = 17'h11; b_dout = 8'h12;
      cyc(); b_wr = 0;
      chk("pair_we",   32'(b_we), 32'h1);
      chk("pair_addr", 32'(b_raddr), 32'h08);
      chk("pair_data", 32'(b_rdata), 32'h1234);
      chk("pair_wait", 32'(b_wait), 1);
      cyc();
      chk("pair_hold_wait", 32'(b_wait), 1);
      b_ready = 1; cyc();
      chk("pair_rel_we",   32'(b_we), 0);
      chk("pair_rel_wait", 32'(b_wait), 0);
      chk("pair_err",      32'(b_err), 0);
      b_dl = 0; cyc();
      chk("pair_done", 32'(b_done), 1);
      cyc();

      // 16-bit: session ends with a half word pending
      b_dl = 1; cyc();
      b_wr = 1; b_addr = 17'h20; b_dout = 8'h9A; cyc();
      b_wr = 0; b_dl = 0; cyc();
      chk("flush_we",   32'(b_we), 32'h1);
      chk("flush_addr", 32'(b_raddr), 32'h10);
      chk("flush_data", 32'(b_rdata), 32'hFF9A);
      chk("flush_done_early", 32'(b_done), 0);
      cyc();
      chk("flush_done", 32'(b_done), 1);
      chk("flush_rel_we", 32'(b_we), 0);
      cyc();
      chk("flush_done_pulse", 32'(b_done), 0);

      // 16-bit: asynchronous reset in the middle of a write
      b_dl = 1; cyc();
      b_ready = 0; b_wr = 1; b_addr = 17'h30; b_dout = 8'h01; cyc();
      b_addr = 17'h31; b_dout = 8'h02; cyc(); b_wr = 0;
      chk("mid_we", 32'(b_we), 32'h1);
      #2 reset_n = 1'b0; #1;
      chk("arst_we",   32'(b_we), 0);
      chk("arst_addr", 32'(b_raddr), 0);
      chk("arst_data", 32'(b_rdata), 0);
      chk("arst_wait", 32'(b_wait), 0);
      chk("arst_done", 32'(b_done), 0);
      cyc(); cyc();
      reset_n = 1'b1; b_ready = 1;
      cyc(); cyc(); cyc();
      chk("post_rst_we",   32'(b_we), 0);
      chk("post_rst_done", 32'(b_done), 0);
      b_dl = 0; cyc();
      chk("post_rst_fall_done", 32'(b_done), 0);
      cyc();

      // 16-bit: odd byte with no preceding even byte
      b_dl = 1; cyc();
      b_wr = 1; b_addr = 17'h41; b_dout = 8'h77; cyc(); b_wr = 0;
      chk("odd_we",   32'(b_we), 32'h1);
      chk("odd_addr", 32'(b_raddr), 32'h20);
      chk("odd_data", 32'(b_rdata), 32'h77FF);
      chk("odd_err",  32'(b_err), 1);
      cyc();
      b_dl = 0; cyc();
      chk("odd_done", 32'(b_done), 1);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
